dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory request interface. The datapath issues load/store requests; this block accepts them, applies a fixed wait-state latency, and returns read data or write completion.
- Word-addressed internal storage with byte-strobe writes.
- Sits beside datapath under the mips top, on the same clk/rstn.

---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// LATENCY, then returns read data or write completion with an out-of-range flag.
//
// Handshake: a request is accepted on a rising edge where req=1 and addr_ok=1
// (addr_ok is combinational, high only in IDLE or RESP). The initiator holds req
// and its fields stable until accepted. data_ok is a one-cycle pulse; rdata and
// err are meaningful only while it is high.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                accept;
  logic                enter_resp;

  logic                lat_wr;
  logic                lat_oor;
  logic [ADDR_W-1:0]   lat_idx;
  logic [3:0]          lat_strb;
  logic [31:0]         lat_wdata;

  logic                in_oor;
  logic                c_wr;
  logic                c_oor;
  logic [ADDR_W-1:0]   c_idx;
  logic [3:0]          c_strb;
  logic [31:0]         c_wdata;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  assign in_oor = |addr[31:ADDR_W+2];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = req;
        if (req) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        addr_ok = req;
        if (req) begin
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = req & addr_ok;
  // RESP can only be re-entered from RESP via a new accept, so this marks every entry.
  assign enter_resp = (state_nxt == RESP);
  assign data_ok    = (state == RESP);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= 4'd1;
    end else if (state == WAIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_wr    <= 1'b0;
      lat_oor   <= 1'b0;
      lat_idx   <= '0;
      lat_strb  <= 4'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      lat_wr    <= wr;
      lat_oor   <= in_oor;
      lat_idx   <= addr[ADDR_W+1:2];
      lat_strb  <= wstrb;
      lat_wdata <= wdata;
    end
  end

  // With LATENCY=1 the RESP-entry edge is the accept edge itself, so the
  // commit must use the live request fields rather than the latched copy.
  assign c_wr    = (LATENCY == 1) ? wr                : lat_wr;
  assign c_oor   = (LATENCY == 1) ? in_oor            : lat_oor;
  assign c_idx   = (LATENCY == 1) ? addr[ADDR_W+1:2]  : lat_idx;
  assign c_strb  = (LATENCY == 1) ? wstrb             : lat_strb;
  assign c_wdata = (LATENCY == 1) ? wdata             : lat_wdata;

  // Storage is intentionally not reset; rstn only blocks a commit during reset.
  always_ff @(posedge clk) begin
    if (rstn && enter_resp && c_wr && !c_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (c_strb[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end else if (enter_resp) begin
      err   <= c_oor;
      rdata <= (c_wr || c_oor) ? 32'd0 : mem[c_idx];
    end else begin
      rdata <= 32'd0;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 3) share
// the request inputs; each scenario checks only the instance it targets.
module tb_dmem_responder;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  logic        a_ok2, d_ok2, er2;
  logic [31:0] rd2;
  logic [1:0]  st2;
  logic        a_ok1, d_ok1, er1;
  logic [31:0] rd1;
  logic [1:0]  st1;
  logic        a_ok3, d_ok3, er3;
  logic [31:0] rd3;
  logic [1:0]  st3;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(a_ok2), .data_ok(d_ok2), .rdata(rd2), .err(er2),
    .state_dbg(st2)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(a_ok1), .data_ok(d_ok1), .rdata(rd1), .err(er1),
    .state_dbg(st1)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(a_ok3), .data_ok(d_ok3), .rdata(rd3), .err(er3),
    .state_dbg(st3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    req   = r;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
  endtask

  // One full transaction on the LATENCY=2 instance, starting from IDLE.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    drive(1'b1, w, a, s, d);
    @(negedge clk);
    chk({tag, "_addr_ok"}, 32'(a_ok2), 32'd1);
    chk({tag, "_c0_data_ok"}, 32'(d_ok2), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_c1_data_ok"}, 32'(d_ok2), 32'd0);
    chk({tag, "_c1_addr_ok"}, 32'(a_ok2), 32'd0);
    @(negedge clk);
    chk({tag, "_c2_data_ok"}, 32'(d_ok2), 32'd1);
    chk({tag, "_rdata"}, rd2, exp_rd);
    chk({tag, "_err"}, 32'(er2), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_c3_data_ok"}, 32'(d_ok2), 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rstn = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_data_ok", 32'(d_ok2), 32'd0);
      chk("idle_rdata", rd2, 32'd0);
      chk("idle_err", 32'(er2), 32'd0);
      chk("idle_addr_ok", 32'(a_ok2), 32'd0);
    end

    // Store then load
    txn("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte strobes
    txn("st20_full", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0);
    txn("st20_strb", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0);
    txn("ld20", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0);
    txn("st20_zero", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
    txn("ld20_again", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0);

    // Out of range: 0x1000 aliases word 0 if the check were missing
    txn("st0", 1'b1, 32'h0, 4'hF, 32'h01234567, 32'h0, 1'b0);
    txn("ld1000", 1'b0, 32'h00001000, 4'h0, 32'h0, 32'h0, 1'b1);
    txn("st1000", 1'b1, 32'h00001000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("ld0", 1'b0, 32'h0, 4'h0, 32'h0, 32'h01234567, 1'b0);
    txn("ldhigh", 1'b0, 32'h80000010, 4'h0, 32'h0, 32'h0, 1'b1);

    // Back-to-back loads, LATENCY=1
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b1_c0_addr_ok", 32'(a_ok1), 32'd1);
    chk("b2b1_c0_data_ok", 32'(d_ok1), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b1_c1_addr_ok", 32'(a_ok1), 32'd1);
    chk("b2b1_c1_data_ok", 32'(d_ok1), 32'd1);
    chk("b2b1_c1_rdata", rd1, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b1_c2_addr_ok", 32'(a_ok1), 32'd1);
    chk("b2b1_c2_data_ok", 32'(d_ok1), 32'd1);
    chk("b2b1_c2_rdata", rd1, 32'h11BB33DD);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b1_c3_addr_ok", 32'(a_ok1), 32'd0);
    chk("b2b1_c3_data_ok", 32'(d_ok1), 32'd1);
    chk("b2b1_c3_rdata", rd1, 32'h01234567);
    chk("b2b1_c3_err", 32'(er1), 32'd0);
    @(negedge clk);
    chk("b2b1_c4_data_ok", 32'(d_ok1), 32'd0);
    repeat (6) @(posedge clk);

    // req held through WAIT, LATENCY=3; second accept lands in the RESP cycle
    #1 drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    @(negedge clk);
    chk("l3_c0_addr_ok", 32'(a_ok3), 32'd1);
    @(negedge clk);
    chk("l3_c1_addr_ok", 32'(a_ok3), 32'd0);
    chk("l3_c1_data_ok", 32'(d_ok3), 32'd0);
    @(negedge clk);
    chk("l3_c2_addr_ok", 32'(a_ok3), 32'd0);
    chk("l3_c2_data_ok", 32'(d_ok3), 32'd0);
    @(negedge clk);
    chk("l3_c3_addr_ok", 32'(a_ok3), 32'd1);
    chk("l3_c3_data_ok", 32'(d_ok3), 32'd1);
    chk("l3_c3_rdata", rd3, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("l3_c4_data_ok", 32'(d_ok3), 32'd0);
    @(negedge clk);
    chk("l3_c5_data_ok", 32'(d_ok3), 32'd0);
    @(negedge clk);
    chk("l3_c6_data_ok", 32'(d_ok3), 32'd1);
    chk("l3_c6_rdata", rd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("l3_c7_data_ok", 32'(d_ok3), 32'd0);
    repeat (8) @(posedge clk);

    // Reset mid-operation on the LATENCY=2 instance
    txn("st30", 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 32'h30, 4'hF, 32'h00000055);
    @(negedge clk);
    chk("rst_addr_ok", 32'(a_ok2), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_c1_data_ok", 32'(d_ok2), 32'd0);
    chk("rst_c1_state", 32'(st2), 32'd0);
    @(negedge clk);
    chk("rst_c2_data_ok", 32'(d_ok2), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_after_data_ok", 32'(d_ok2), 32'd0);
      chk("rst_after_rdata", rd2, 32'd0);
    end
    txn("ld30", 1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
